// File: rtl/regfile_writeback.sv
// ----------------------------------------------------------------------------
// regfile_writeback
//
// Write-side controller for the 32 x 64-bit register file. Results from the
// ALU and the load unit compete for the single write port through a
// valid/ready handshake. The winning result is registered onto the
// we/Rw/din pins one cycle after it is accepted. Writes to x0 are consumed
// but never reach the file. A per-register pending-load mask is kept for
// the issue stage's stall logic.
//
// The register file only refreshes its read ports in cycles with we low.
// For that reason, no more than MAX_BURST consecutive writes are allowed.
// After that, one idle cycle is forced. To keep the load unit from starving
// the ALU, the ALU takes priority after MAX_STALL consecutive stall cycles.
//
// Ports
//   i_clk        rising-edge system clock
//   i_rst_n      asynchronous active-low reset
//   i_alu_valid  ALU result available
//   i_alu_rd     ALU destination register
//   i_alu_data   ALU result
//   o_alu_ready  ALU result accepted this cycle (when i_alu_valid)
//   i_mem_valid  load result available
//   i_mem_rd     load destination register
//   i_mem_data   load data
//   o_mem_ready  load result accepted this cycle (when i_mem_valid)
//   i_ld_issue   load issued this cycle; marks i_ld_rd pending
//   i_ld_rd      destination of the issued load
//   o_rf_we      register file write enable (registered)
//   o_rf_rw      register file write address (registered)
//   o_rf_din     register file write data (registered)
//   o_busy_mask  bit i set while a load to register i is pending (registered)
// ----------------------------------------------------------------------------
module regfile_writeback #(
    parameter int DW        = 64,
    parameter int MAX_BURST = 4,
    parameter int MAX_STALL = 3
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_alu_valid,
    input  logic [4:0]    i_alu_rd,
    input  logic [DW-1:0] i_alu_data,
    output logic          o_alu_ready,
    input  logic          i_mem_valid,
    input  logic [4:0]    i_mem_rd,
    input  logic [DW-1:0] i_mem_data,
    output logic          o_mem_ready,
    input  logic          i_ld_issue,
    input  logic [4:0]    i_ld_rd,
    output logic          o_rf_we,
    output logic [4:0]    o_rf_rw,
    output logic [DW-1:0] o_rf_din,
    output logic [31:0]   o_busy_mask
);

    localparam int BW = $clog2(MAX_BURST + 1);
    localparam int SW = $clog2(MAX_STALL + 1);
    localparam logic [BW-1:0] BURST_LIMIT = BW'(MAX_BURST);
    localparam logic [SW-1:0] STALL_LIMIT = SW'(MAX_STALL);

    logic          r_rfWe;
    logic [4:0]    r_rfRw;
    logic [DW-1:0] r_rfDin;
    logic [31:0]   r_busyMask;
    logic [BW-1:0] r_burstCnt;
    logic [SW-1:0] r_stallCnt;

    logic          w_gate;
    logic          w_starve;
    logic          w_aluReady;
    logic          w_memReady;
    logic          w_aluAccept;
    logic          w_memAccept;
    logic          w_accept;
    logic [4:0]    w_accRd;
    logic [DW-1:0] w_accData;
    logic          w_accWrite;
    logic [31:0]   w_busyNext;

    // Handshake arbitration. Memory normally wins, but the ALU takes over
    // once it has been stalled for MAX_STALL cycles. Both readies drop for
    // one cycle when the burst limit is reached, and they stay low while
    // reset is asserted.
    always_comb begin
        w_gate      = (r_burstCnt != BURST_LIMIT);
        w_starve    = (r_stallCnt == STALL_LIMIT);
        w_memReady  = i_rst_n & w_gate & ~(w_starve & i_alu_valid);
        w_aluReady  = i_rst_n & w_gate & (~i_mem_valid | w_starve);
        w_memAccept = i_mem_valid & w_memReady;
        w_aluAccept = i_alu_valid & w_aluReady;
        w_accept    = w_memAccept | w_aluAccept;
        w_accRd     = w_memAccept ? i_mem_rd   : i_alu_rd;
        w_accData   = w_memAccept ? i_mem_data : i_alu_data;
        w_accWrite  = w_accept & (w_accRd != 5'd0);
    end

    // Pending-load mask update. The issue side is applied after the
    // completion side, so a set and a clear of the same register in one
    // cycle leave the bit set. x0 can never be pending.
    always_comb begin
        w_busyNext = r_busyMask;
        if (w_memAccept && (i_mem_rd != 5'd0)) begin
            w_busyNext[i_mem_rd] = 1'b0;
        end
        if (i_ld_issue && (i_ld_rd != 5'd0)) begin
            w_busyNext[i_ld_rd] = 1'b1;
        end
        w_busyNext[0] = 1'b0;
    end

    // Write port register. An accepted result appears one cycle later. The
    // address and data hold their last value while the write enable is low.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rfWe  <= 1'b0;
            r_rfRw  <= 5'd0;
            r_rfDin <= '0;
        end else begin
            r_rfWe <= w_accWrite;
            if (w_accWrite) begin
                r_rfRw  <= w_accRd;
                r_rfDin <= w_accData;
            end
        end
    end

    // Burst and stall counters. The burst counter counts consecutive real
    // writes. Any cycle without one clears it, including the forced idle
    // cycle. The stall counter saturates so that the ALU keeps priority
    // until it is actually served.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_burstCnt <= '0;
            r_stallCnt <= '0;
        end else begin
            r_burstCnt <= w_accWrite ? (r_burstCnt + BW'(1)) : '0;
            if (!i_alu_valid || w_aluAccept) begin
                r_stallCnt <= '0;
            end else if (r_stallCnt != STALL_LIMIT) begin
                r_stallCnt <= r_stallCnt + SW'(1);
            end
        end
    end

    // Pending-load mask register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_busyMask <= '0;
        end else begin
            r_busyMask <= w_busyNext;
        end
    end

    assign o_alu_ready = w_aluReady;
    assign o_mem_ready = w_memReady;
    assign o_rf_we     = r_rfWe;
    assign o_rf_rw     = r_rfRw;
    assign o_rf_din    = r_rfDin;
    assign o_busy_mask = r_busyMask;

endmodule

// File: tb/tb_regfile_writeback.sv
// ----------------------------------------------------------------------------
// tb_regfile_writeback
//
// Directed bench for regfile_writeback. Stimulus pushes the register-file
// writes it expects onto a queue. An independent monitor pops one entry for
// every cycle the DUT raises rf_we and compares the address and data.
// Handshake, burst shape, pending-load mask and reset behaviour are checked
// directly against hand-computed constants.
// ----------------------------------------------------------------------------
module tb_regfile_writeback;

    typedef struct packed {
        logic [4:0]  rd;
        logic [63:0] data;
    } wrExp_t;

    logic        clk;
    logic        rstN;
    logic        aluValid;
    logic [4:0]  aluRd;
    logic [63:0] aluData;
    logic        aluReady;
    logic        memValid;
    logic [4:0]  memRd;
    logic [63:0] memData;
    logic        memReady;
    logic        ldIssue;
    logic [4:0]  ldRd;
    logic        rfWe;
    logic [4:0]  rfRw;
    logic [63:0] rfDin;
    logic [31:0] busyMask;

    wrExp_t expQ[$];
    int     testsRun  = 0;
    int     failCount = 0;

    regfile_writeback #(
        .DW(64),
        .MAX_BURST(4),
        .MAX_STALL(3)
    ) dut (
        .i_clk(clk),
        .i_rst_n(rstN),
        .i_alu_valid(aluValid),
        .i_alu_rd(aluRd),
        .i_alu_data(aluData),
        .o_alu_ready(aluReady),
        .i_mem_valid(memValid),
        .i_mem_rd(memRd),
        .i_mem_data(memData),
        .o_mem_ready(memReady),
        .i_ld_issue(ldIssue),
        .i_ld_rd(ldRd),
        .o_rf_we(rfWe),
        .o_rf_rw(rfRw),
        .o_rf_din(rfDin),
        .o_busy_mask(busyMask)
    );

    // 10-time-unit clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Drive every DUT input in one go
    task automatic applyStimulus(input logic av, input logic [4:0] ar,
                                 input logic [63:0] ad, input logic mv,
                                 input logic [4:0] mr, input logic [63:0] md,
                                 input logic li, input logic [4:0] lr);
        aluValid = av;
        aluRd    = ar;
        aluData  = ad;
        memValid = mv;
        memRd    = mr;
        memData  = md;
        ldIssue  = li;
        ldRd     = lr;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every write the DUT presents must match the oldest expectation
    initial begin
        wrExp_t e;
        forever begin
            @(negedge clk);
            if (rstN && rfWe) begin
                if (expQ.size() == 0) begin
                    testsRun++;
                    failCount++;
                    $display("[TB] FAIL unexpected_write: got rw=%0d din=%h, expected no write",
                             rfRw, rfDin);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("sb_rw", 64'(rfRw), 64'(e.rd));
                    checkOutput("sb_din", rfDin, e.data);
                end
            end
        end
    end

    initial begin
        logic [9:0] weBits;
        logic [9:0] weExp;
        logic [4:0] memRds[6];
        logic [5:0] memRdyExp;
        logic [5:0] aluRdyExp;
        int         idx;
        logic       acc;

        // ---- Reset state, readies forced low while in reset ----
        rstN = 1'b0;
        idle();
        aluValid = 1'b1;
        memValid = 1'b1;
        @(negedge clk);
        checkOutput("reset_we", 64'(rfWe), 64'd0);
        checkOutput("reset_rw", 64'(rfRw), 64'd0);
        checkOutput("reset_din", rfDin, 64'd0);
        checkOutput("reset_busy", 64'(busyMask), 64'd0);
        checkOutput("reset_alu_ready", 64'(aluReady), 64'd0);
        checkOutput("reset_mem_ready", 64'(memReady), 64'd0);
        tick();
        rstN = 1'b1;
        idle();
        tick();

        // ---- Single ALU write ----
        applyStimulus(1'b1, 5'd5, 64'hA5, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0);
        expQ.push_back('{rd: 5'd5, data: 64'hA5});
        @(negedge clk);
        checkOutput("single_alu_ready", 64'(aluReady), 64'd1);
        tick();
        idle();
        @(negedge clk);
        checkOutput("single_we", 64'(rfWe), 64'd1);
        tick();
        tick();

        // ---- Both valid: mem first, ALU starved 3 cycles, then burst gap ----
        memRds    = '{5'd3, 5'd10, 5'd11, 5'd12, 5'd12, 5'd12};
        memRdyExp = 6'b100111;
        aluRdyExp = 6'b001000;
        expQ.push_back('{rd: 5'd3,  data: 64'h3000});
        expQ.push_back('{rd: 5'd10, data: 64'h3001});
        expQ.push_back('{rd: 5'd11, data: 64'h3002});
        expQ.push_back('{rd: 5'd7,  data: 64'h7777});
        expQ.push_back('{rd: 5'd12, data: 64'h3003});
        idx = 0;
        for (int c = 0; c < 6; c++) begin
            applyStimulus(c < 4, 5'd7, 64'h7777, 1'b1, memRds[c],
                          64'h3000 + 64'(idx), 1'b0, 5'd0);
            @(negedge clk);
            checkOutput($sformatf("arb_mem_ready_c%0d", c), 64'(memReady), 64'(memRdyExp[c]));
            checkOutput($sformatf("arb_alu_ready_c%0d", c), 64'(aluReady), 64'(aluRdyExp[c]));
            acc = memValid & memReady;
            tick();
            if (acc) idx++;
        end
        idle();
        tick();
        tick();

        // ---- Six back-to-back ALU writes with MAX_BURST=4 ----
        for (int i = 0; i < 6; i++) begin
            expQ.push_back('{rd: 5'(16 + i), data: 64'hB00 + 64'(i)});
        end
        weExp = 10'b0011011110;
        idx   = 0;
        for (int c = 0; c < 10; c++) begin
            applyStimulus(idx < 6, 5'(16 + idx), 64'hB00 + 64'(idx),
                          1'b0, 5'd0, 64'd0, 1'b0, 5'd0);
            @(negedge clk);
            weBits[c] = rfWe;
            acc = aluValid & aluReady;
            tick();
            if (acc) idx++;
        end
        checkOutput("burst_we_pattern", 64'(weBits), 64'(weExp));
        idle();
        tick();

        // ---- Pending-load scoreboard ----
        applyStimulus(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd9);
        tick();
        idle();
        @(negedge clk);
        checkOutput("busy_set9", 64'(busyMask), 64'h200);
        tick();
        applyStimulus(1'b0, 5'd0, 64'd0, 1'b1, 5'd9, 64'h99, 1'b0, 5'd0);
        expQ.push_back('{rd: 5'd9, data: 64'h99});
        tick();
        idle();
        @(negedge clk);
        checkOutput("busy_clear9", 64'(busyMask), 64'h0);
        tick();
        applyStimulus(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd9);
        tick();
        applyStimulus(1'b0, 5'd0, 64'd0, 1'b1, 5'd9, 64'h9A, 1'b1, 5'd9);
        expQ.push_back('{rd: 5'd9, data: 64'h9A});
        tick();
        idle();
        @(negedge clk);
        checkOutput("busy_set_wins", 64'(busyMask), 64'h200);
        tick();
        applyStimulus(1'b0, 5'd0, 64'd0, 1'b1, 5'd9, 64'h9B, 1'b1, 5'd4);
        expQ.push_back('{rd: 5'd9, data: 64'h9B});
        tick();
        idle();
        @(negedge clk);
        checkOutput("busy_set4_clear9", 64'(busyMask), 64'h10);
        tick();
        applyStimulus(1'b1, 5'd6, 64'h66, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0);
        expQ.push_back('{rd: 5'd6, data: 64'h66});
        tick();
        idle();
        @(negedge clk);
        checkOutput("alu_keeps_busy", 64'(busyMask), 64'h10);
        tick();

        // ---- x0 destination: consumed, never written, never pending ----
        applyStimulus(1'b1, 5'd0, 64'hDEAD, 1'b0, 5'd0, 64'd0, 1'b1, 5'd0);
        @(negedge clk);
        checkOutput("x0_alu_ready", 64'(aluReady), 64'd1);
        tick();
        idle();
        @(negedge clk);
        checkOutput("x0_no_we", 64'(rfWe), 64'd0);
        checkOutput("x0_busy", 64'(busyMask), 64'h10);
        tick();

        // ---- Asynchronous reset mid-cycle with a write in flight ----
        applyStimulus(1'b1, 5'd20, 64'hC0FFEE, 1'b0, 5'd0, 64'd0, 1'b1, 5'd22);
        tick();
        idle();
        #2;
        rstN = 1'b0;
        #1;
        checkOutput("async_rst_we", 64'(rfWe), 64'd0);
        checkOutput("async_rst_rw", 64'(rfRw), 64'd0);
        checkOutput("async_rst_din", rfDin, 64'd0);
        checkOutput("async_rst_busy", 64'(busyMask), 64'd0);
        tick();
        rstN = 1'b1;
        tick();

        // After reset, the write path must work from a clean state
        applyStimulus(1'b1, 5'd1, 64'h11, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0);
        expQ.push_back('{rd: 5'd1, data: 64'h11});
        tick();
        idle();
        tick();
        tick();

        checkOutput("sb_drained", 64'(expQ.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
